// File: rtl/irq_controller.sv
// Interrupt front-end for the multicycle MIPS core: synchronises and
// edge-detects IRQ/NMI lines, masks, arbitrates and tracks one in-service IRQ.
module irq_controller #(
    parameter int          N_IRQ       = 8,
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0180,
    parameter logic [N_IRQ-1:0] MASK_RESET = {N_IRQ{1'b1}},
    localparam int         IW          = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             nmi_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             int_ack,
    input  logic             eoi,
    input  logic             nmi_ack,
    output logic             int_out,
    output logic             intd_out,
    output logic             nmi_out,
    output logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] pending,
    output logic [IW-1:0]    int_id,
    output logic [31:0]      vector
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t state_q, state_d;

    logic [N_IRQ-1:0] sync1_q, sync1_d;
    logic [N_IRQ-1:0] sync2_q, sync2_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic             nsync1_q, nsync1_d;
    logic             nsync2_q, nsync2_d;
    logic             nmi_q, nmi_d;
    logic [IW-1:0]    id_q, id_d;
    logic [31:0]      vector_q, vector_d;

    logic [N_IRQ-1:0] irq_edge;
    logic             nmi_edge;
    logic [N_IRQ-1:0] req;
    logic [N_IRQ-1:0] req_d;
    logic [N_IRQ-1:0] win_oh;
    logic [IW-1:0]    win_id;
    logic [N_IRQ-1:0] clr;
    logic             ack_take;

    // Two-stage synchroniser; sync2 also serves as the previous-sample
    // stage, so an edge is flagged the cycle it enters sync2.
    always_comb begin
        sync1_d  = irq_in;
        sync2_d  = sync1_q;
        nsync1_d = nmi_in;
        nsync2_d = nsync1_q;
        irq_edge = sync1_q & ~sync2_q;
        nmi_edge = nsync1_q & ~nsync2_q;
    end

    // Fixed priority: lowest unmasked pending index wins.
    always_comb begin
        req    = pending_q & ~mask_q;
        win_id = '0;
        win_oh = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id = IW'(i);
                win_oh = N_IRQ'(1) << i;
            end
        end
    end

    // Pending/mask/NMI update and FSM next state; set beats clear.
    always_comb begin
        ack_take  = (state_q == REQ) && int_ack;
        clr       = ack_take ? win_oh : '0;
        pending_d = (pending_q & ~clr) | irq_edge;
        mask_d    = mask_we ? mask_wdata : mask_q;
        req_d     = pending_d & ~mask_d;
        nmi_d     = (nmi_q & ~nmi_ack) | nmi_edge;
        state_d   = state_q;
        id_d      = id_q;
        vector_d  = vector_q;
        unique case (state_q)
            IDLE, REQ: begin
                if (ack_take) begin
                    state_d  = SERVICE;
                    id_d     = win_id;
                    vector_d = VECTOR_BASE + (32'(win_id) << 2);
                end else begin
                    state_d = (|req_d) ? REQ : IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d = (|req_d) ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            nsync1_q  <= 1'b0;
            nsync2_q  <= 1'b0;
            pending_q <= '0;
            mask_q    <= MASK_RESET;
            nmi_q     <= 1'b0;
            id_q      <= '0;
            vector_q  <= VECTOR_BASE;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            nsync1_q  <= nsync1_d;
            nsync2_q  <= nsync2_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            nmi_q     <= nmi_d;
            id_q      <= id_d;
            vector_q  <= vector_d;
        end
    end

    assign int_out  = (state_q == REQ);
    assign intd_out = (state_q == SERVICE);
    assign nmi_out  = nmi_q;
    assign mask     = mask_q;
    assign pending  = pending_q;
    assign int_id   = id_q;
    assign vector   = vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_irq_controller;

    localparam int N = 8;
    localparam logic [31:0] VB = 32'h0000_0180;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;
    logic         nmi_in;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic         int_ack;
    logic         eoi;
    logic         nmi_ack;
    logic         int_out;
    logic         intd_out;
    logic         nmi_out;
    logic [N-1:0] mask;
    logic [N-1:0] pending;
    logic [2:0]   int_id;
    logic [31:0]  vector;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    irq_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .nmi_in     (nmi_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .nmi_ack    (nmi_ack),
        .int_out    (int_out),
        .intd_out   (intd_out),
        .nmi_out    (nmi_out),
        .mask       (mask),
        .pending    (pending),
        .int_id     (int_id),
        .vector     (vector)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Behavioural model: inputs sampled at each edge, an edge counts once
    // the line was seen 0 two edges back and 1 one edge back.
    logic [N-1:0] h1 = '0, h2 = '0;
    logic         n1 = 1'b0, n2 = 1'b0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_mask = '1;
    logic         m_nmi = 1'b0;
    logic         m_svc = 1'b0;
    int           m_id = 0;

    always @(posedge clk) begin
        logic [N-1:0] edges;
        logic [N-1:0] r;
        logic         ne;
        int           g;
        if (reset) begin
            h1 = '0; h2 = '0; n1 = 0; n2 = 0;
            m_pend = '0; m_mask = '1; m_nmi = 0;
            m_svc = 0; m_id = 0;
        end else begin
            edges = h1 & ~h2;
            ne    = n1 & ~n2;
            h2 = h1; h1 = irq_in;
            n2 = n1; n1 = nmi_in;
            r = m_pend & ~m_mask;
            g = -1;
            for (int i = 0; i < N; i++)
                if (r[i] && g < 0) g = i;
            if (m_svc) begin
                if (eoi) m_svc = 0;
            end else if (int_ack && g >= 0) begin
                m_svc = 1;
                m_id  = g;
                m_pend[g] = 1'b0;
            end
            m_pend = m_pend | edges;
            if (mask_we) m_mask = mask_wdata;
            if (nmi_ack) m_nmi = 0;
            if (ne) m_nmi = 1;
        end
    end

    // Compare DUT against the model every cycle, mid-period.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_int_out", 32'(int_out),
                32'(!m_svc && |(m_pend & ~m_mask)));
            chk("m_intd_out", 32'(intd_out), 32'(m_svc));
            chk("m_nmi_out", 32'(nmi_out), 32'(m_nmi));
            chk("m_mask", 32'(mask), 32'(m_mask));
            chk("m_pending", 32'(pending), 32'(m_pend));
            chk("m_int_id", 32'(int_id), 32'(m_id));
            chk("m_vector", vector, VB + 32'(4 * m_id));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulses_off();
        mask_we = 0; int_ack = 0; eoi = 0; nmi_ack = 0;
    endtask

    task automatic wmask(input logic [N-1:0] v);
        mask_we = 1; mask_wdata = v;
        tick();
        mask_we = 0;
    endtask

    initial begin
        reset = 1; irq_in = '0; nmi_in = 0; mask_wdata = '0;
        pulses_off();
        tick(); tick();
        chk_en = 1;
        chk("rst_int_out", 32'(int_out), 0);
        chk("rst_vector", vector, 32'h180);
        chk("rst_mask", 32'(mask), 32'hFF);
        reset = 0;

        // Single request
        wmask(8'h00);
        irq_in[3] = 1; tick(); irq_in[3] = 0; tick();
        chk("single_int_out", 32'(int_out), 1);
        int_ack = 1; tick(); int_ack = 0;
        chk("single_intd", 32'(intd_out), 1);
        chk("single_id", 32'(int_id), 3);
        chk("single_vec", vector, 32'h18C);
        chk("single_pend3", 32'(pending[3]), 0);
        eoi = 1; tick(); eoi = 0;

        // Priority
        irq_in = 8'h24; tick(); irq_in = '0; tick();
        int_ack = 1; tick(); int_ack = 0;
        chk("prio_id", 32'(int_id), 2);
        chk("prio_vec", vector, 32'h188);
        eoi = 1; tick(); eoi = 0;
        chk("prio_reint", 32'(int_out), 1);
        int_ack = 1; tick(); int_ack = 0;
        chk("prio_id2", 32'(int_id), 5);
        eoi = 1; tick(); eoi = 0;

        // Masking
        wmask(8'h01);
        irq_in[0] = 1; tick(); irq_in[0] = 0; tick();
        chk("mask_pend0", 32'(pending[0]), 1);
        chk("mask_int_out", 32'(int_out), 0);
        wmask(8'h00);
        chk("unmask_int_out", 32'(int_out), 1);
        int_ack = 1; tick(); int_ack = 0;

        // No nesting and ack/eoi collision
        irq_in[1] = 1; tick(); irq_in[1] = 0; tick();
        chk("nest_int_out", 32'(int_out), 0);
        chk("nest_pend1", 32'(pending[1]), 1);
        int_ack = 1; eoi = 1; tick(); pulses_off();
        chk("coll_intd", 32'(intd_out), 0);
        chk("coll_int_out", 32'(int_out), 1);
        chk("coll_id", 32'(int_id), 0);

        // NMI while in service, fully masked
        int_ack = 1; tick(); int_ack = 0;
        wmask(8'hFF);
        nmi_in = 1; tick(); tick();
        chk("nmi_set", 32'(nmi_out), 1);
        nmi_in = 0; tick(); tick();
        nmi_in = 1; tick();
        nmi_ack = 1; tick(); nmi_ack = 0;
        chk("nmi_collide", 32'(nmi_out), 1);
        nmi_ack = 1; tick(); nmi_ack = 0;
        chk("nmi_clear", 32'(nmi_out), 0);

        // Reset mid-service with a held line
        chk("pre_rst_intd", 32'(intd_out), 1);
        irq_in[4] = 1;
        reset = 1; tick(); reset = 0;
        chk("mid_rst_pend", 32'(pending), 0);
        chk("mid_rst_intd", 32'(intd_out), 0);
        chk("mid_rst_nmi", 32'(nmi_out), 0);
        chk("mid_rst_id", 32'(int_id), 0);
        chk("mid_rst_mask", 32'(mask), 32'hFF);
        tick();
        chk("post_rst_e1", 32'(pending[4]), 0);
        tick();
        chk("post_rst_e2", 32'(pending[4]), 1);
        chk("post_rst_int", 32'(int_out), 0);
        irq_in = '0; nmi_in = 0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
            if ($urandom_range(15) == 0) nmi_in = ~nmi_in;
            mask_we    = ($urandom_range(19) == 0);
            mask_wdata = N'($urandom);
            int_ack    = ($urandom_range(3) == 0);
            eoi        = ($urandom_range(5) == 0);
            nmi_ack    = ($urandom_range(7) == 0);
            reset      = ($urandom_range(499) == 0);
            tick();
        end
        pulses_off(); reset = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
